// File: rtl/tickgen_pkg.sv
// Shared constants, divisor type and channel-index width helper for tick_generator.
package tickgen_pkg;

    localparam int TICKGEN_DEFAULT_DIV = 100_000;
    localparam int TICKGEN_CNT_W       = 18;

    typedef logic [TICKGEN_CNT_W-1:0] div_t;

    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One timebase channel: period counter, active/shadow divisor, tick strobe and square wave.
module tick_channel
    import tickgen_pkg::*;
#(
    parameter int CNT_W       = TICKGEN_CNT_W,
    parameter int DEFAULT_DIV = TICKGEN_DEFAULT_DIV
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_adv,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_pending,
    output logic             o_tick,
    output logic             o_sq
);

    logic [CNT_W-1:0] r_ctr;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pending;
    logic             r_tick;
    logic             r_sq;

    logic             w_wrap;
    logic [CNT_W-1:0] w_div_clamped;

    assign w_wrap        = (r_ctr == (r_div - CNT_W'(1)));
    assign w_div_clamped = (i_div == '0) ? CNT_W'(1) : i_div;

    // The shadow only reaches r_div at a wrap, so r_ctr is 0 whenever the compare value changes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ctr     <= '0;
            r_div     <= CNT_W'(DEFAULT_DIV);
            r_shadow  <= CNT_W'(DEFAULT_DIV);
            r_pending <= 1'b0;
            r_tick    <= 1'b0;
            r_sq      <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (i_adv) begin
                if (w_wrap) begin
                    r_ctr  <= '0;
                    r_tick <= 1'b1;
                    r_sq   <= ~r_sq;
                    if (r_pending) begin
                        r_div     <= r_shadow;
                        r_pending <= 1'b0;
                    end
                end else begin
                    r_ctr <= r_ctr + CNT_W'(1);
                end
            end
            if (i_load) begin
                r_shadow  <= w_div_clamped;
                r_pending <= 1'b1;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_tick    = r_tick;
    assign o_sq      = r_sq;

endmodule

// File: rtl/tick_generator.sv
// Multi-channel programmable timebase: shared advance strobe, per-channel tick/sq, divisor handshake.
// Optional common prescaler is built when TICKGEN_PRESCALE_EN is defined.
module tick_generator
    import tickgen_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = TICKGEN_CNT_W,
    parameter int DEFAULT_DIV = TICKGEN_DEFAULT_DIV,
    parameter int PRESCALE    = 100
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_en,
    input  logic                           i_cfg_valid,
    input  logic [ch_idx_w(NUM_CH)-1:0]    i_cfg_ch,
    input  logic [CNT_W-1:0]               i_cfg_div,
    output logic                           o_cfg_ready,
    output logic [NUM_CH-1:0]              o_tick,
    output logic [NUM_CH-1:0]              o_sq
);

    localparam int CH_W = ch_idx_w(NUM_CH);

    logic              w_adv;
    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_load;

`ifdef TICKGEN_PRESCALE_EN
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PRE_W-1:0] r_pre_cnt;
    logic             w_pre_wrap;

    assign w_pre_wrap = (r_pre_cnt == PRE_W'(PRESCALE - 1));

    // Prescaler phase freezes with en so a pause shifts every edge by exactly its length.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pre_cnt <= '0;
        end else if (i_en) begin
            r_pre_cnt <= w_pre_wrap ? '0 : r_pre_cnt + PRE_W'(1);
        end
    end

    assign w_adv = i_en & w_pre_wrap;
`else
    // A ratio below 1 is meaningless; such a build simply never advances.
    assign w_adv = i_en & (PRESCALE > 0);
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_load[g] = i_cfg_valid & ~w_pending[g] & (i_cfg_ch == CH_W'(g));

        tick_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_adv     (w_adv),
            .i_load    (w_load[g]),
            .i_div     (i_cfg_div),
            .o_pending (w_pending[g]),
            .o_tick    (o_tick[g]),
            .o_sq      (o_sq[g])
        );
    end

    // Out-of-range channel indices match nothing, so they read ready and load nowhere.
    always_comb begin
        o_cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i_cfg_ch == CH_W'(i)) o_cfg_ready = ~w_pending[i];
        end
    end

endmodule

// File: tb/tb_tick_generator.sv
// Directed bench for tick_generator: ticks, square wave, divisor handshake, enable, reset, prescaler.
module tb_tick_generator;

`ifdef TICKGEN_PRESCALE_EN
    localparam int TB_DEF_DIV = 2;
`else
    localparam int TB_DEF_DIV = 10;
`endif

    logic        clk;
    logic        rst;
    logic        en;
    logic        cfg_valid;
    logic [0:0]  cfg_ch;
    logic [17:0] cfg_div;
    logic        cfg_ready;
    logic [1:0]  tick;
    logic [1:0]  sq;

    int          checks;
    int          errors;
    int          cyc;
    logic [1:0]  exp_t;
    logic [1:0]  exp_s;
    logic        exp_r;

    tick_generator #(
        .NUM_CH      (2),
        .CNT_W       (18),
        .DEFAULT_DIV (TB_DEF_DIV),
        .PRESCALE    (3)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_cfg_valid (cfg_valid),
        .i_cfg_ch    (cfg_ch),
        .i_cfg_div   (cfg_div),
        .o_cfg_ready (cfg_ready),
        .o_tick      (tick),
        .o_sq        (sq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = 1'b1;
        cfg_div   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        en    = 1'b1;
        cyc   = 0;
        exp_s = '0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        en        = 1'b1;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tick !== 2'b00) begin
            errors++;
            $display("FAIL reset_tick got=%b exp=00", tick);
        end
        checks++;
        if (sq !== 2'b00) begin
            errors++;
            $display("FAIL reset_sq got=%b exp=00", sq);
        end
        for (int c = 0; c < 2; c++) begin
            cfg_ch = c[0:0];
            #1;
            checks++;
            if (cfg_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready ch=%0d got=%b exp=1", c, cfg_ready);
            end
        end
    endtask

    // ch1 gets div 4 at cycle 3; applies at its wrap in cycle 10.
    task automatic test_update();
        do_reset();
        for (int c = 1; c <= 30; c++) begin
            step();
            exp_t[0] = (cyc % 10 == 0);
            exp_t[1] = (cyc == 10) || (cyc > 10 && (cyc - 10) % 4 == 0);
            exp_s    = exp_s ^ exp_t;
            checks++;
            if (tick !== exp_t) begin
                errors++;
                $display("FAIL update_tick cyc=%0d got=%b exp=%b", cyc, tick, exp_t);
            end
            checks++;
            if (sq !== exp_s) begin
                errors++;
                $display("FAIL update_sq cyc=%0d got=%b exp=%b", cyc, sq, exp_s);
            end
            cfg_valid = (cyc == 2);
            cfg_ch    = 1'b1;
            cfg_div   = 18'd4;
            #1;
            exp_r = !(cyc >= 3 && cyc <= 9);
            checks++;
            if (cfg_ready !== exp_r) begin
                errors++;
                $display("FAIL update_ready cyc=%0d got=%b exp=%b", cyc, cfg_ready, exp_r);
            end
        end
        cfg_valid = 1'b0;
    endtask

    // Second write to ch1 held against a pending one; accepted right after the wrap.
    task automatic test_stall();
        do_reset();
        for (int c = 1; c <= 22; c++) begin
            step();
            exp_t[0] = (cyc % 10 == 0);
            exp_t[1] = (cyc == 10) || (cyc == 14) || (cyc >= 16 && cyc % 2 == 0);
            exp_s    = exp_s ^ exp_t;
            checks++;
            if (tick !== exp_t) begin
                errors++;
                $display("FAIL stall_tick cyc=%0d got=%b exp=%b", cyc, tick, exp_t);
            end
            checks++;
            if (sq !== exp_s) begin
                errors++;
                $display("FAIL stall_sq cyc=%0d got=%b exp=%b", cyc, sq, exp_s);
            end
            cfg_valid = (cyc == 2) || (cyc >= 4 && cyc <= 10);
            cfg_ch    = 1'b1;
            cfg_div   = (cyc == 2) ? 18'd4 : 18'd2;
            #1;
            exp_r = !((cyc >= 3 && cyc <= 9) || (cyc >= 11 && cyc <= 13));
            checks++;
            if (cfg_ready !== exp_r) begin
                errors++;
                $display("FAIL stall_ready cyc=%0d got=%b exp=%b", cyc, cfg_ready, exp_r);
            end
        end
        cfg_valid = 1'b0;
    endtask

    // Accept lands on ch0's wrap edge: that wrap keeps the old divisor.
    task automatic test_back_to_back();
        do_reset();
        for (int c = 1; c <= 30; c++) begin
            step();
            exp_t[0] = (cyc == 10) || (cyc == 20) || (cyc == 25) || (cyc == 30);
            exp_t[1] = (cyc % 10 == 0);
            exp_s    = exp_s ^ exp_t;
            checks++;
            if (tick !== exp_t) begin
                errors++;
                $display("FAIL b2b_tick cyc=%0d got=%b exp=%b", cyc, tick, exp_t);
            end
            checks++;
            if (sq !== exp_s) begin
                errors++;
                $display("FAIL b2b_sq cyc=%0d got=%b exp=%b", cyc, sq, exp_s);
            end
            cfg_valid = (cyc == 9);
            cfg_ch    = 1'b0;
            cfg_div   = 18'd5;
            #1;
            exp_r = !(cyc >= 10 && cyc <= 19);
            checks++;
            if (cfg_ready !== exp_r) begin
                errors++;
                $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", cyc, cfg_ready, exp_r);
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_div_zero();
        do_reset();
        for (int c = 1; c <= 16; c++) begin
            step();
            exp_t[0] = (cyc >= 10);
            exp_t[1] = (cyc == 10);
            exp_s    = exp_s ^ exp_t;
            checks++;
            if (tick !== exp_t) begin
                errors++;
                $display("FAIL div0_tick cyc=%0d got=%b exp=%b", cyc, tick, exp_t);
            end
            checks++;
            if (sq !== exp_s) begin
                errors++;
                $display("FAIL div0_sq cyc=%0d got=%b exp=%b", cyc, sq, exp_s);
            end
            cfg_valid = (cyc == 2);
            cfg_ch    = 1'b0;
            cfg_div   = 18'd0;
        end
        cfg_valid = 1'b0;
    endtask

    // en low for edges 5..9 shifts every tick by 5.
    task automatic test_enable();
        do_reset();
        for (int c = 1; c <= 25; c++) begin
            step();
            exp_t[0] = (cyc == 15) || (cyc == 25);
            exp_t[1] = exp_t[0];
            exp_s    = exp_s ^ exp_t;
            checks++;
            if (tick !== exp_t) begin
                errors++;
                $display("FAIL enable_tick cyc=%0d got=%b exp=%b", cyc, tick, exp_t);
            end
            checks++;
            if (sq !== exp_s) begin
                errors++;
                $display("FAIL enable_sq cyc=%0d got=%b exp=%b", cyc, sq, exp_s);
            end
            en = !(cyc >= 4 && cyc <= 8);
        end
        en = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 1; c <= 19; c++) begin
            step();
            exp_t[0] = (cyc == 10);
            exp_t[1] = exp_t[0];
            checks++;
            if (tick !== exp_t) begin
                errors++;
                $display("FAIL rstmid_pre_tick cyc=%0d got=%b exp=%b", cyc, tick, exp_t);
            end
            cfg_valid = (cyc == 15);
            cfg_ch    = 1'b1;
            cfg_div   = 18'd3;
        end
        cfg_valid = 1'b0;
        rst       = 1'b1;
        step();
        checks++;
        if (tick !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_tick got=%b exp=00", tick);
        end
        checks++;
        if (sq !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_sq got=%b exp=00", sq);
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready got=%b exp=1", cfg_ready);
        end
        rst = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            exp_t[0] = (cyc == 10);
            exp_t[1] = exp_t[0];
            checks++;
            if (tick !== exp_t) begin
                errors++;
                $display("FAIL rstmid_post_tick cyc=%0d got=%b exp=%b", cyc, tick, exp_t);
            end
        end
    endtask

    // PRESCALE 3, div 2: ticks every 6 cycles; en low on edges 8..9 shifts later ticks by 2.
    task automatic test_prescale();
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            step();
            exp_t[0] = (cyc == 6) || (cyc == 14) || (cyc == 20);
            exp_t[1] = exp_t[0];
            exp_s    = exp_s ^ exp_t;
            checks++;
            if (tick !== exp_t) begin
                errors++;
                $display("FAIL prescale_tick cyc=%0d got=%b exp=%b", cyc, tick, exp_t);
            end
            checks++;
            if (sq !== exp_s) begin
                errors++;
                $display("FAIL prescale_sq cyc=%0d got=%b exp=%b", cyc, sq, exp_s);
            end
            en = !(cyc == 7 || cyc == 8);
        end
        en = 1'b1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        exp_t     = '0;
        exp_s     = '0;
        exp_r     = 1'b1;
        rst       = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = 1'b0;
        cfg_div   = '0;
        test_reset();
`ifdef TICKGEN_PRESCALE_EN
        test_prescale();
`else
        test_update();
        test_stall();
        test_back_to_back();
        test_div_zero();
        test_enable();
        test_reset_mid();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_generator.md
# tick_generator

Multi-channel, run-time-programmable timebase generator: the parametrised successor to the single fixed display-multiplexing timer. It produces, per channel, a one-cycle `tick` strobe and a 50 % duty square wave `sq` from the system clock. It sits next to the top level and feeds display scan, debounce sampling and other periodic consumers. Dividers reload through a valid/ready handshake and take effect only at a period boundary, so they never glitch.

## Interface
- `NUM_CH`, 2: number of independent channels (≥1).
- `CNT_W`, 18: width of each channel counter and divisor.
- `DEFAULT_DIV`, 100_000: divisor loaded into every channel at reset; 500 Hz `sq` at 100 MHz.
- `PRESCALE`, 100: common prescaler ratio, used only with `TICKGEN_PRESCALE_EN`.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: global run enable.
- `cfg_valid` in 1: divisor update request.
- `cfg_ch` in max(1,$clog2(NUM_CH)): target channel.
- `cfg_div` in CNT_W: new divisor.
- `cfg_ready` out 1: update can be accepted for `cfg_ch`.
- `tick` out NUM_CH: one-cycle strobe per channel period.
- `sq` out NUM_CH: square wave; toggles once per channel period.

## Operation
- Advance strobe `adv`:
  - `adv` = `en` each cycle when no prescaler is built in.
  - With the prescaler, see Configuration.
- Per channel: `ctr` counts 0..div−1 on each `adv`. On `adv` with `ctr == div−1`:
  - `ctr` ← 0.
  - `tick` ← 1 for exactly one cycle.
  - `sq` ← ~`sq`.
  - If an update is pending: `div` ← `shadow`, and pending clears.
- `en` = 0: counters and prescaler hold, `tick` = 0, `sq` holds its level.
- Handshake:
  - `cfg_ready` = ~pending[`cfg_ch`], combinational.
  - Transfer occurs when `cfg_valid` && `cfg_ready`: `shadow[cfg_ch]` ← `cfg_div` and pending is set.
  - One pending slot per channel. A second write to the same channel stalls until the wrap.
  - `cfg_ch` ≥ `NUM_CH`: `cfg_ready` = 1, the write is dropped, no state changes.
- Divisor 0 is clamped to 1 on acceptance. Divisor 1 gives `tick` on every `adv` and `sq` toggling every `adv`.
- Accept and wrap in the same cycle: the wrap uses the old `div`. The new value applies at the following wrap.
- Counter compare uses the active `div` only. Loading a `div` smaller than the current `ctr` is impossible, because a load happens only when `ctr` returns to 0.

## Timing
- Reset values:
  - `tick` = 0, `sq` = 0, `ctr` = 0, `div` = `DEFAULT_DIV`.
  - pending = 0, prescaler = 0.
  - `cfg_ready` = 1.
- `rst` mid-period aborts the period immediately and discards pending updates.
- All outputs are registered except `cfg_ready`.
- Without prescaler, `en` = 1 from the first cycle after reset, divisor D:
  - `tick` is high in cycles D, 2D, 3D, …, counting cycle 1 as the first after reset deasserts.
  - `sq` changes in those same cycles; its period is 2D cycles.
- Update latency: from handshake to new period start = remaining cycles of the current period, 1..D.

## Configuration
- Macro: `TICKGEN_PRESCALE_EN`.
- Defined:
  - A shared counter 0..PRESCALE−1 advances when `en` = 1.
  - `adv` pulses when it wraps.
  - All channel periods scale by `PRESCALE`: first `tick` at cycle D·PRESCALE.
- Undefined:
  - No prescaler hardware.
  - `PRESCALE` is ignored.
  - `adv` = `en`.

## Structure
- Package `tickgen_pkg`:
  - `DEFAULT_DIV` default constant.
  - Channel-index width function.
  - Typedef `div_t` (logic [CNT_W-1:0]), generalised via a parameterised width localparam.
- Sub-module `tick_channel`, instantiated `NUM_CH` times via generate. It holds `ctr`, `div`, `shadow`, pending, `tick` and `sq`.
- The top level holds the prescaler, `adv` generation, `cfg_ch` decode and the `cfg_ready` mux.

## Test plan
- Reset, `en` = 1, macro off, `DEFAULT_DIV` = 10 → `tick[0]` high in cycles 10, 20, 30; `sq[0]` rises at 10 and falls at 20.
- Write ch1 `cfg_div` = 4 at cycle 3 → `cfg_ready` low until ch1 wraps at cycle 10; ch1 then ticks at 14, 18; ch0 is unaffected.
- Second write to ch1 while pending → stalled, `cfg_ready` = 0; `cfg_valid` held high → accepted in the wrap cycle, with the new value applied one period later.
- `cfg_div` = 0 → behaves as 1: `tick` continuous every cycle, `sq` toggles every cycle.
- `en` low for 5 cycles mid-period → every `tick` edge shifts by 5 and `sq` holds; `rst` asserted mid-period → all outputs return to reset values next cycle.
- Macro on, `PRESCALE` = 3, div = 2 → `tick` at cycles 6, 12; `en` drop also freezes the prescaler phase.
